// File: rtl/attopu_seq.sv
// attopu_seq: multi-cycle fetch/exec/mem sequencer for the attopu core.
// It owns the PC, the instruction register, the return-address stack,
// the sticky fault flag and the FETCH/EXEC/MEM/HALT state machine.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   imem_*             fetch req/ack handshake; address = pc
//   dmem_*             data req/ack handshake; we = store
//   c_flag, z_flag     ALU flags sampled in EXEC
//   reg_rdata1         jump-register target and data address
//   reg_*_sel, alu_op  ir fields driven to the datapath
//   reg_we, reg_src    register write-back control
//   imm_data           zero-extended ir[10:0]
//   pc, sp             current PC and stack occupancy
//   retire             one-cycle pulse per completed instruction
//   halted, fault      HALT state indicator and sticky stack fault
module attopu_seq #(
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 4,
   parameter int RESET_PC    = 0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic                                 imem_req,
   output logic [ADDR_W-1:0]                    imem_addr,
   input  logic                                 imem_ack,
   input  logic [15:0]                          imem_rdata,
   output logic                                 dmem_req,
   output logic                                 dmem_we,
   input  logic                                 dmem_ack,
   input  logic                                 c_flag,
   input  logic                                 z_flag,
   input  logic [ADDR_W-1:0]                    reg_rdata1,
   output logic [1:0]                           reg_in_sel,
   output logic [1:0]                           reg_out_sel1,
   output logic [1:0]                           reg_out_sel2,
   output logic [6:0]                           alu_op,
   output logic                                 reg_we,
   output logic [1:0]                           reg_src,
   output logic [ADDR_W-1:0]                    imm_data,
   output logic [ADDR_W-1:0]                    pc,
   output logic                                 retire,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
   output logic                                 halted,
   output logic                                 fault
);

   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
   localparam logic [SPW-1:0]    SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0]    SP_FULL = SPW'(STACK_DEPTH);
   localparam logic [IW-1:0]     IX_ONE  = IW'(1);

   localparam logic [2:0] OP_ALU  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_CALL = 3'b010;
   localparam logic [2:0] OP_LD   = 3'b011;
   localparam logic [2:0] OP_SYS  = 3'b100;
   localparam logic [2:0] OP_ST   = 3'b101;
   localparam logic [2:0] OP_BR   = 3'b110;
   localparam logic [2:0] OP_JR   = 3'b111;

   typedef enum logic [1:0] {
      FETCH,
      EXEC,
      MEM,
      HALT
   } state_e;

   state_e            state;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] pcReg;
   logic [SPW-1:0]    spReg;
   logic              faultReg;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic [2:0]        opcode;
   logic [ADDR_W-1:0] pcNext;
   logic [ADDR_W-1:0] brTarget;
   logic              brCond;
   logic              stackFull;
   logic              stackEmpty;
   logic [IW-1:0]     pushIdx;
   logic [IW-1:0]     popIdx;
   logic              inExec;
   logic              inMem;
   logic              execRetire;

   assign opcode     = ir[15:13];
   assign pcNext     = pcReg + PC_ONE;
   assign brTarget   = ADDR_W'($signed(ir[10:0]));
   assign brCond     = ir[12] ? (ir[11] == z_flag)
                              : (ir[11] == c_flag);
   assign stackFull  = (spReg == SP_FULL);
   assign stackEmpty = (spReg == '0);
   // sp <= STACK_DEPTH <= 2**IW, so the low IW bits
   // minus one still address the top entry when full.
   assign pushIdx    = spReg[IW-1:0];
   assign popIdx     = pushIdx - IX_ONE;

   // Gating on rst_n keeps the reset cycle free of
   // requests, writes and retire pulses.
   assign inExec = rst_n && (state == EXEC);
   assign inMem  = rst_n && (state == MEM);

   always_comb begin
      execRetire = 1'b0;
      unique case (opcode)
         OP_ALU, OP_LDI, OP_BR, OP_JR: execRetire = 1'b1;
         OP_CALL:                      execRetire = !stackFull;
         OP_SYS:  execRetire = ir[12] || !stackEmpty;
         OP_LD, OP_ST:                 execRetire = 1'b0;
      endcase
   end

   assign imem_req     = rst_n && (state == FETCH);
   assign imem_addr    = pcReg;
   assign dmem_req     = inMem;
   assign dmem_we      = inMem && (opcode == OP_ST);
   assign reg_we       = (inExec && (opcode == OP_ALU ||
                                     opcode == OP_LDI)) ||
                         (inMem && dmem_ack &&
                          opcode == OP_LD);
   assign reg_src      = inMem ? 2'b10 :
                         (opcode == OP_LDI) ? 2'b01 : 2'b00;
   assign retire       = (inExec && execRetire) ||
                         (inMem && dmem_ack);
   assign reg_in_sel   = ir[12:11];
   assign reg_out_sel1 = ir[10:9];
   assign reg_out_sel2 = ir[8:7];
   assign alu_op       = ir[6:0];
   assign imm_data     = ADDR_W'(ir[10:0]);
   assign pc           = pcReg;
   assign sp           = spReg;
   assign halted       = (state == HALT);
   assign fault        = faultReg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= FETCH;
         pcReg    <= PC_INIT;
         ir       <= '0;
         spReg    <= '0;
         faultReg <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_rdata;
                  state <= EXEC;
               end
            end
            EXEC: begin
               state <= FETCH;
               unique case (opcode)
                  OP_ALU, OP_LDI: pcReg <= pcNext;
                  OP_LD, OP_ST:   state <= MEM;
                  OP_BR: pcReg <= brCond ? brTarget : pcNext;
                  OP_JR: pcReg <= z_flag ? reg_rdata1 : pcNext;
                  OP_CALL: begin
                     if (stackFull) begin
                        faultReg <= 1'b1;
                        state    <= HALT;
                     end else begin
                        stack[pushIdx] <= pcNext;
                        spReg          <= spReg + SP_ONE;
                        pcReg          <= brTarget;
                     end
                  end
                  OP_SYS: begin
                     if (ir[12]) begin
                        state <= HALT;
                     end else if (stackEmpty) begin
                        faultReg <= 1'b1;
                        state    <= HALT;
                     end else begin
                        pcReg <= stack[popIdx];
                        spReg <= spReg - SP_ONE;
                     end
                  end
               endcase
            end
            MEM: begin
               if (dmem_ack) begin
                  pcReg <= pcNext;
                  state <= FETCH;
               end
            end
            HALT: begin
               state <= HALT;
            end
         endcase
      end
   end

endmodule
